// File: rtl/vga_sync_gen.sv
// VGA raster timing (default 640x480@60): sync pulses, pixel coordinates, visible flag, pixel tick.
// Optional VGA_SYNC_RGB_OUT_EN adds a gated RGB output with hsync/vsync delayed one clk to line up.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_SYNC_RGB_OUT_EN
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
`endif
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    // Totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_p_tick;
    logic             r_video_on;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [DIV_W-1:0] w_div_nxt;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_von_nxt;
    logic             w_hs_nxt;
    logic             w_vs_nxt;

    always_comb begin
        w_tick    = (r_div == DIV_LAST);
        w_h_wrap  = (r_h == H_LAST);
        w_v_wrap  = (r_v == V_LAST);
        w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (w_tick) begin
            w_h_nxt = w_h_wrap ? 10'd0 : r_h + 10'd1;
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? 10'd0 : r_v + 10'd1;
            end
        end
    end

    // Flags are decoded from the next-state position so they register on the same edge as the coordinates.
    always_comb begin
        w_von_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
        w_hs_nxt  = ((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        w_vs_nxt  = ((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    // p_tick is high in the clk that begins each new pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_p_tick      <= 1'b0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_p_tick      <= w_tick;
            r_video_on    <= w_von_nxt;
            r_hsync       <= w_hs_nxt;
            r_vsync       <= w_vs_nxt;
            r_frame_start <= w_tick & w_h_wrap & w_v_wrap;
        end
    end

`ifdef VGA_SYNC_RGB_OUT_EN
    logic       r_hsync_d;
    logic       r_vsync_d;
    logic [2:0] r_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync_d <= ~SYNC_POL;
            r_vsync_d <= ~SYNC_POL;
            r_rgb     <= 3'b000;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
            r_rgb     <= r_video_on ? rgb_in : 3'b000;
        end
    end

    assign rgb_out = r_rgb;
    assign hsync   = r_hsync_d;
    assign vsync   = r_vsync_d;
`else
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
`endif

    assign p_tick      = r_p_tick;
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-timing instances (CLK_DIV=2 active-low, CLK_DIV=3 active-high)
// checked every clk against a closed-form position model, plus a hand-derived vector table.
module tb_vga_sync_gen;
    localparam int HD = 16, HF = 4, HSW = 6, HB = 4;
    localparam int VD = 8, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int NV = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic a_pt, a_von, a_hs, a_vs, a_fs;
    logic b_pt, b_von, b_hs, b_vs, b_fs;
`ifdef VGA_SYNC_RGB_OUT_EN
    logic [2:0] rgb_in;
    logic [2:0] a_rgb, b_rgb;
`endif

    vga_sync_gen #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                   .CLK_DIV(2), .SYNC_POL(1'b0)) u_a (
        .clk(clk), .rst(rst),
`ifdef VGA_SYNC_RGB_OUT_EN
        .rgb_in(rgb_in), .rgb_out(a_rgb),
`endif
        .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs));

    vga_sync_gen #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                   .CLK_DIV(3), .SYNC_POL(1'b1)) u_b (
        .clk(clk), .rst(rst),
`ifdef VGA_SYNC_RGB_OUT_EN
        .rgb_in(rgb_in), .rgb_out(b_rgb),
`endif
        .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs));

    int n_clk  = 0;
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic von, hs, vs, pt, fs;
    } exp_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit von, hs, vs, pt, fs;
    } vec_t;
    vec_t tv [NV];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    // n = clks since reset release; pixel ticks elapsed = n / cd, position = ticks mod frame size.
    function automatic exp_t model(input int n, input int cd, input bit pol);
        exp_t e;
        int t, p, x, y;
        e.x = '0; e.y = '0; e.von = 1'b0; e.hs = ~pol; e.vs = ~pol; e.pt = 1'b0; e.fs = 1'b0;
        if (n > 0) begin
            t = n / cd;
            p = t % (HT * VT);
            x = p % HT;
            y = p / HT;
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.von = (x < HD) && (y < VD);
            e.hs  = (x >= HD + HF && x < HD + HF + HSW) ? pol : ~pol;
            e.vs  = (y >= VD + VF && y < VD + VF + VSW) ? pol : ~pol;
            e.pt  = (n % cd == 0);
            e.fs  = e.pt && (p == 0);
        end
        return e;
    endfunction

    task automatic chk_dut(input string nm, input int cd, input bit pol,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic von, input logic hs, input logic vs,
                           input logic pt, input logic fs
`ifdef VGA_SYNC_RGB_OUT_EN
                           , input logic [2:0] rgb
`endif
                           );
        exp_t e;
        e = model(n_clk, cd, pol);
        cmp({nm, ".pixel_x"}, 32'(x), 32'(e.x));
        cmp({nm, ".pixel_y"}, 32'(y), 32'(e.y));
        cmp({nm, ".video_on"}, 32'(von), 32'(e.von));
        cmp({nm, ".p_tick"}, 32'(pt), 32'(e.pt));
        cmp({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
`ifdef VGA_SYNC_RGB_OUT_EN
        begin
            exp_t ep;
            ep = model(n_clk - 1, cd, pol);
            cmp({nm, ".hsync"}, 32'(hs), 32'(ep.hs));
            cmp({nm, ".vsync"}, 32'(vs), 32'(ep.vs));
            cmp({nm, ".rgb_out"}, 32'(rgb), ep.von ? 32'(rgb_in) : 32'd0);
        end
`else
        cmp({nm, ".hsync"}, 32'(hs), 32'(e.hs));
        cmp({nm, ".vsync"}, 32'(vs), 32'(e.vs));
`endif
    endtask

    always @(posedge clk) begin
        if (rst) n_clk = 0;
        else     n_clk = n_clk + 1;
        #1;
        if (chk_en) begin
`ifdef VGA_SYNC_RGB_OUT_EN
            chk_dut("a", 2, 1'b0, a_x, a_y, a_von, a_hs, a_vs, a_pt, a_fs, a_rgb);
            chk_dut("b", 3, 1'b1, b_x, b_y, b_von, b_hs, b_vs, b_pt, b_fs, b_rgb);
`else
            chk_dut("a", 2, 1'b0, a_x, a_y, a_von, a_hs, a_vs, a_pt, a_fs);
            chk_dut("b", 3, 1'b1, b_x, b_y, b_von, b_hs, b_vs, b_pt, b_fs);
`endif
        end
    end

    initial begin
        int guard;
        int hold;
        // {n, x, y, video_on, hsync, vsync, p_tick, frame_start} for instance a (CLK_DIV=2, active-low)
        tv[0]  = '{0,   0,  0,  0, 1, 1, 0, 0};
        tv[1]  = '{1,   0,  0,  1, 1, 1, 0, 0};
        tv[2]  = '{2,   1,  0,  1, 1, 1, 1, 0};
        tv[3]  = '{3,   1,  0,  1, 1, 1, 0, 0};
        tv[4]  = '{20,  10, 0,  1, 1, 1, 1, 0};
        tv[5]  = '{31,  15, 0,  1, 1, 1, 0, 0};
        tv[6]  = '{32,  16, 0,  0, 1, 1, 1, 0};
        tv[7]  = '{39,  19, 0,  0, 1, 1, 0, 0};
        tv[8]  = '{40,  20, 0,  0, 0, 1, 1, 0};
        tv[9]  = '{51,  25, 0,  0, 0, 1, 0, 0};
        tv[10] = '{52,  26, 0,  0, 1, 1, 1, 0};
        tv[11] = '{59,  29, 0,  0, 1, 1, 0, 0};
        tv[12] = '{60,  0,  1,  1, 1, 1, 1, 0};
        tv[13] = '{480, 0,  8,  0, 1, 1, 1, 0};
        tv[14] = '{600, 0,  10, 0, 1, 0, 1, 0};
        tv[15] = '{720, 0,  12, 0, 1, 1, 1, 0};
        tv[16] = '{899, 29, 14, 0, 1, 1, 0, 0};
        tv[17] = '{900, 0,  0,  1, 1, 1, 1, 1};
        tv[18] = '{901, 0,  0,  1, 1, 1, 0, 0};
`ifdef VGA_SYNC_RGB_OUT_EN
        rgb_in = 3'b110;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk_en = 1'b1;
        repeat (137) @(posedge clk);

        // 3-clk reset mid-count, then walk the vector table
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < NV; i++) begin
            guard = 0;
            while (n_clk < tv[i].n && guard < 2000) begin
                @(posedge clk); #2;
                guard++;
            end
            if (n_clk != tv[i].n) cmp("tv_reach", 32'(n_clk), 32'(tv[i].n));
            cmp($sformatf("tv%0d.pixel_x", i), 32'(a_x), 32'(tv[i].x));
            cmp($sformatf("tv%0d.pixel_y", i), 32'(a_y), 32'(tv[i].y));
            cmp($sformatf("tv%0d.video_on", i), 32'(a_von), 32'(tv[i].von));
            cmp($sformatf("tv%0d.p_tick", i), 32'(a_pt), 32'(tv[i].pt));
            cmp($sformatf("tv%0d.frame_start", i), 32'(a_fs), 32'(tv[i].fs));
`ifndef VGA_SYNC_RGB_OUT_EN
            cmp($sformatf("tv%0d.hsync", i), 32'(a_hs), 32'(tv[i].hs));
            cmp($sformatf("tv%0d.vsync", i), 32'(a_vs), 32'(tv[i].vs));
`endif
            if (rst) begin
                @(negedge clk) rst = 1'b0;
            end
        end

        // mid-frame reset at (10,5)
        guard = 0;
        while (!(a_x == 10'd10 && a_y == 10'd5) && guard < 3000) begin
            @(posedge clk); #2;
            guard++;
        end
        cmp("mid_reach", 32'(a_x == 10'd10 && a_y == 10'd5), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #2;
        cmp("mid_rst.pixel_x", 32'(a_x), 32'd0);
        cmp("mid_rst.pixel_y", 32'(a_y), 32'd0);
        cmp("mid_rst.video_on", 32'(a_von), 32'd0);
        cmp("mid_rst.p_tick", 32'(a_pt), 32'd0);
        cmp("mid_rst.frame_start", 32'(a_fs), 32'd0);
        cmp("mid_rst.hsync", 32'(a_hs), 32'd1);
        cmp("mid_rst.vsync", 32'(a_vs), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #2;
        cmp("mid_exit.pixel_x", 32'(a_x), 32'd0);
        cmp("mid_exit.video_on", 32'(a_von), 32'd1);
        cmp("mid_exit.frame_start", 32'(a_fs), 32'd0);

        // long randomized run with sporadic resets; the per-clk model check covers it
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (rst) begin
                if (hold == 0) rst = 1'b0;
                else hold--;
            end else if (c > 2000 && $urandom_range(0, 999) == 0) begin
                rst  = 1'b1;
                hold = int'($urandom_range(0, 3));
            end
        end
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
